// File: rtl/mc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : mc_pkg                                                          |
// | Brief    : Shared state, opcode/funct and control-field encodings for the  |
// |            multicycle MIPS-64 main controller.                             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        ADDIEX = 4'd8,
        ANDIEX = 4'd9,
        ORIEX  = 4'd10,
        IWB    = 4'd11,
        BEQ    = 4'd12,
        BNE    = 4'd13,
        JMP    = 4'd14,
        ERR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_DADD = 6'b101100;
    localparam logic [5:0] F_DSUB = 6'b101110;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] SRCB_RT       = 3'd0;
    localparam logic [2:0] SRCB_FOUR     = 3'd1;
    localparam logic [2:0] SRCB_SIGNIMM  = 3'd2;
    localparam logic [2:0] SRCB_BRANCH   = 3'd3;
    localparam logic [2:0] SRCB_ZEROIMM  = 3'd4;

    localparam logic [1:0] PCSRC_ALURES = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] LT_WORD = 2'd0;
    localparam logic [1:0] LT_BU   = 2'd1;
    localparam logic [1:0] LT_B    = 2'd2;

    function automatic logic is_load(input logic [5:0] opc);
        return (opc == OP_LW) || (opc == OP_LD) || (opc == OP_LB) || (opc == OP_LBU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_aludec.sv
// +----------------------------------------------------------------------------+
// | Module   : mc_aludec                                                       |
// | Brief    : R-type funct decoder -> ALU operation, 64/32-bit select, valid. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_aludec
    import mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] funct,
    output logic [2:0]     alucontrol,
    output logic           dtype,
    output logic           valid
);

    always_comb begin
        alucontrol = ALU_ADD;
        dtype      = 1'b0;
        valid      = 1'b1;
        case (funct)
            F_ADD:  alucontrol = ALU_ADD;
            F_SUB:  alucontrol = ALU_SUB;
            F_AND:  alucontrol = ALU_AND;
            F_OR:   alucontrol = ALU_OR;
            F_SLT:  alucontrol = ALU_SLT;
            F_DADD: begin
                alucontrol = ALU_ADD;
                dtype      = 1'b1;
            end
            F_DSUB: begin
                alucontrol = ALU_SUB;
                dtype      = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// +----------------------------------------------------------------------------+
// | Module   : mc_controller                                                   |
// | Brief    : Multicycle MIPS-64 main controller (3-5 cycles per instruction).|
// |            MC_CTRL_MEMWAIT_EN adds a memready handshake on memory states. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_controller
    import mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
`ifdef MC_CTRL_MEMWAIT_EN
    input  logic           memready,
`endif
    output logic           pcen,
    output logic           irwrite,
    output logic           regwrite,
    output logic           memwrite,
    output logic           dtype,
    output logic           iord,
    output logic           memtoreg,
    output logic           regdst,
    output logic           alusrca,
    output logic [2:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [2:0]     alucontrol,
    output logic [1:0]     ltype,
    output logic           illegal,
    output logic [SW-1:0]  state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    state_t w_out_st;
    logic   w_mem_ready;
    logic [2:0] w_r_alu;
    logic   w_r_dtype;
    logic   w_r_valid;

`ifdef MC_CTRL_MEMWAIT_EN
    assign w_mem_ready = memready;
`else
    assign w_mem_ready = 1'b1;
`endif

    mc_aludec #(.OPW(OPW)) u_aludec (
        .funct      (funct),
        .alucontrol (w_r_alu),
        .dtype      (w_r_dtype),
        .valid      (w_r_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (w_mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_LD, OP_LB, OP_LBU, OP_SW, OP_SD: state_d = MEMADR;
                    OP_RTYPE:          state_d = REX;
                    OP_ADDI, OP_DADDI: state_d = ADDIEX;
                    OP_ANDI:           state_d = ANDIEX;
                    OP_ORI:            state_d = ORIEX;
                    OP_BEQ:            state_d = BEQ;
                    OP_BNE:            state_d = BNE;
                    OP_J:              state_d = JMP;
                    default:           state_d = ERR;
                endcase
            end
            MEMADR: state_d = is_load(op) ? MEMRD : MEMWR;
            MEMRD:  if (w_mem_ready) state_d = MEMWB;
            MEMWR:  if (w_mem_ready) state_d = FETCH;
            REX:    state_d = w_r_valid ? RWB : ERR;
            ADDIEX, ANDIEX, ORIEX: state_d = IWB;
            ERR:    state_d = ERR;
            default: state_d = FETCH;
        endcase
        illegal_d = illegal_q | (state_d == ERR);
    end

    // During reset the outputs show the FETCH decode with every write strobe suppressed.
    assign w_out_st = reset ? FETCH : state_q;

    always_comb begin
        pcen       = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        dtype      = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALURES;
        alucontrol = ALU_AND;
        ltype      = LT_WORD;
        case (w_out_st)
            FETCH: begin
                irwrite    = w_mem_ready;
                pcen       = w_mem_ready;
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
                dtype      = 1'b1;
                pcsrc      = PCSRC_ALURES;
            end
            DECODE: begin
                alusrcb    = SRCB_BRANCH;
                alucontrol = ALU_ADD;
                dtype      = 1'b1;
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_SIGNIMM;
                alucontrol = ALU_ADD;
                dtype      = 1'b1;
            end
            MEMRD: begin
                iord  = 1'b1;
                ltype = (op == OP_LB) ? LT_B : ((op == OP_LBU) ? LT_BU : LT_WORD);
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = w_mem_ready;
            end
            REX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = w_r_alu;
                dtype      = w_r_dtype;
            end
            RWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                alucontrol = w_r_alu;
                dtype      = w_r_dtype;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_SIGNIMM;
                alucontrol = ALU_ADD;
                dtype      = (op == OP_DADDI);
            end
            ANDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_ZEROIMM;
                alucontrol = ALU_AND;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_ZEROIMM;
                alucontrol = ALU_OR;
            end
            IWB: regwrite = 1'b1;
            BEQ, BNE: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = ALU_SUB;
                dtype      = 1'b1;
                pcsrc      = PCSRC_ALUOUT;
                pcen       = (w_out_st == BEQ) ? zero : ~zero;
            end
            JMP: begin
                pcsrc = PCSRC_JUMP;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    assign illegal = illegal_q & ~reset;
    assign state   = SW'(state_q);

endmodule

`default_nettype wire
